// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder cell iterated LSB first
// One operand bit pair per clock; {C_out, S} = A + B + C after WIDTH shift cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic             cy_q, cy_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sum_bit, carry;
  logic [WIDTH-1:0] r_shift;

  assign sum_bit = a_q[0] ^ b_q[0] ^ cy_q;
  assign carry   = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  // The new sum bit enters at the MSB so bit 0 ends up in r_shift[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_r1
      assign r_shift = sum_bit;
    end else begin : g_rn
      assign r_shift = {sum_bit, r_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      SHIFT: begin
        cy_d  = carry;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = r_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = r_shift;
          cout_d  = carry;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          cy_d    = C;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign C_out = cout_q;

endmodule
